uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- 8N1 asynchronous serial receiver for the RS-232 input, clocked from the 50 MHz global clock.
- Sits directly upstream of the program loader and delivers one byte per single-cycle strobe for SRAM commit.
- Samples at 16x oversampling with a 3-sample majority vote at mid-bit, and rejects false starts and framing errors.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, sample ticks per bit; must be ≥8 and even.
- TICK_DIV, CLK_HZ/(BAUD*OVERSAMPLE) truncated (27 at defaults), clocks per sample tick; elaboration error if <2.

Ports:
- clk  in  1  global clock.
- rst  in  1  synchronous active-high reset.
- rx  in  1  raw serial line, asynchronous, idle high.
- byte_out  out  8  last good received byte; held until the next good byte.
- byte_valid  out  1  one-cycle strobe; byte_out is valid in the same cycle.
- frame_err  out  1  one-cycle strobe on bad stop bit.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: byte_out=0, byte_valid=0, frame_err=0, busy=0, FSM=IDLE, synchronizer flops=1, tick counter=0. Reset mid-frame aborts the frame with no strobes.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Tick generator: counter 0..TICK_DIV-1 produces a one-cycle tick at wrap. It is held at 0 in IDLE and restarted on start detection, so sample phase aligns to the falling edge.
- Sample counter s: 0..OVERSAMPLE-1, advances on tick. Mid-bit samples are taken at s = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 (7, 8, 9 at default). The bit value is the majority of the three, resolved on the tick at s=9.
- State IDLE: on rxs 1→0 go to START with s=0.
- State START: if the majority is 1, treat as a false start and return to IDLE; no strobes. Otherwise continue until s wraps, then go to DATA with bit index 0.
- State DATA: 8 bits, LSB first, shifted into an internal shift register. After bit 7 wraps, go to STOP.
- State STOP, majority resolved:
  - Majority 1: byte_out←shift register, byte_valid=1 on the next clk, then IDLE immediately. No wait for the stop-bit end, so back-to-back frames are accepted.
  - Majority 0: frame_err=1 on the next clk, byte_out unchanged, go to BREAK.
- State BREAK: wait until rxs=1, then IDLE. A held-low line produces exactly one frame_err.
- Strobes are never asserted together and are never held longer than one cycle.
- A falling edge seen in IDLE on the cycle directly after leaving STOP is honoured.
- Latency from the rx stop-bit mid-sample tick to byte_valid: 1 clk, plus 2 clk of synchronizer delay relative to the pin.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP.
  - Adds parameter PARITY_ODD (default 0, even).
  - Adds output parity_err (1 bit, reset 0), a one-cycle strobe issued in place of byte_valid when the stop bit is good but parity mismatches; byte_out is unchanged in that case.
  - A framing error takes precedence over a parity error.
- When undefined: the frame is 8N1, with no parity_err port and no PARITY state.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - Localparam MID_SAMPLE = OVERSAMPLE/2.
  - Function majority3.
  - Function tick_div(clk_hz, baud, os).
- One sub-module, uart_tick_gen (clk, rst, clear, tick), for the divider counter. It is reusable by a future uart_tx.

Test Plan:
- Default params, one bit = 432 clk. Send 0x55 then 0xA3 with no idle gap → two byte_valid strobes, byte_out 0x55 then 0xA3, no frame_err.
- rx low pulse of 100 clk on an idle line → no strobes, busy returns 0 within 16 ticks, FSM in IDLE.
- Frame 0x3C with the stop bit driven low, rx held low 5000 clk, then high, then send 0x7E → exactly one frame_err, byte_out stays at prior value, next byte_valid with 0x7E.
- 20-clk glitch inverting data bit 3 away from mid-bit while sending 0x0F → byte_out 0x0F (majority vote immune).
- Assert rst for 1 clk mid-data of 0xFF, then send 0x81 → no strobe for the aborted frame, byte_out reset to 0x00, then 0x81 valid.
- UART_RX_PARITY_EN defined, even parity: send 0x07 with parity bit 0 → parity_err strobe, no byte_valid; send 0x07 with parity 1 → byte_valid with 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared receiver state encoding, mid-bit constant and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    localparam int c_DEFAULT_OVERSAMPLE = 16;
    localparam int MID_SAMPLE           = c_DEFAULT_OVERSAMPLE / 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic int tick_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_tick_gen
// Description : Free-running divider emitting a one-cycle tick every DIV clocks;
//               clear holds the count at zero to phase-align to an event.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tick_gen: DIV must be at least 2");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == c_LAST);
    assign tick   = w_wrap && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : 8N1 UART receiver, 16x oversampled with 3-sample mid-bit
//               majority vote, false-start and framing-error rejection.
//               Optional parity check enabled by macro UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = tick_div(CLK_HZ, BAUD, OVERSAMPLE)
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int c_MID = OVERSAMPLE / 2;
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] c_S_A    = SW'(c_MID - 1);
    localparam logic [SW-1:0] c_S_B    = SW'(c_MID);
    localparam logic [SW-1:0] c_S_C    = SW'(c_MID + 1);
    localparam logic [SW-1:0] c_S_LAST = SW'(OVERSAMPLE - 1);

    generate
        if (TICK_DIV < 2) begin : g_tick_div_check
            $error("uart_rx_oversampled: TICK_DIV must be at least 2");
        end
        if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
            $error("uart_rx_oversampled: OVERSAMPLE must be >= 8 and even");
        end
    endgenerate

    logic          r_rx_meta;
    logic          r_rxs;
    logic          r_rxs_d;
    uart_state_t   r_state;
    logic [SW-1:0] r_s;
    logic [2:0]    r_bit;
    logic [1:0]    r_samp;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte_out;
    logic          r_byte_valid;
    logic          r_frame_err;
    logic          r_busy;
    logic          w_tick;
    logic          w_clear;
    logic          w_maj;
`ifdef UART_RX_PARITY_EN
    logic          r_par;
    logic          r_parity_err;
    logic          w_par_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    // Divider is held in IDLE so the first tick lands one tick after the edge.
    assign w_clear = (r_state == ST_IDLE) || (r_state == ST_BREAK);

    uart_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign w_maj = majority3(r_samp[0], r_samp[1], r_rxs);

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = ((^r_shift) ^ r_par) != 1'(PARITY_ODD);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_bit        <= '0;
            r_samp       <= '0;
            r_shift      <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (r_rxs_d && !r_rxs) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (r_rxs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_s <= (r_s == c_S_LAST) ? '0 : r_s + 1'b1;
                        if (r_s == c_S_A) r_samp[0] <= r_rxs;
                        if (r_s == c_S_B) r_samp[1] <= r_rxs;
                        if (r_s == c_S_C) begin
                            case (r_state)
                                ST_START: begin
                                    if (w_maj) begin
                                        r_state <= ST_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end
                                ST_DATA: r_shift <= {w_maj, r_shift[7:1]};
`ifdef UART_RX_PARITY_EN
                                ST_PARITY: r_par <= w_maj;
`endif
                                ST_STOP: begin
                                    if (!w_maj) begin
                                        r_frame_err <= 1'b1;
                                        r_state     <= ST_BREAK;
`ifdef UART_RX_PARITY_EN
                                    end else if (w_par_bad) begin
                                        r_parity_err <= 1'b1;
                                        r_state      <= ST_IDLE;
                                        r_busy       <= 1'b0;
`endif
                                    end else begin
                                        r_byte_out   <= r_shift;
                                        r_byte_valid <= 1'b1;
                                        r_state      <= ST_IDLE;
                                        r_busy       <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        if (r_s == c_S_LAST) begin
                            case (r_state)
                                ST_START: begin
                                    r_state <= ST_DATA;
                                    r_bit   <= '0;
                                end
                                ST_DATA: begin
                                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                        r_state <= ST_PARITY;
`else
                                        r_state <= ST_STOP;
`endif
                                    end else begin
                                        r_bit <= r_bit + 1'b1;
                                    end
                                end
                                ST_PARITY: r_state <= ST_STOP;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Directed self-checking bench for uart_rx_oversampled
//               (parity cases compiled in with UART_RX_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

    localparam int c_BIT = 432;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         n_checks;
    int         n_fail;
    int         vcnt;
    int         fcnt;
    int         pcnt;
    int         bad_strobe;
    logic [7:0] rx_q[$];
    logic       prev_v;
    logic       prev_f;

    uart_rx_oversampled u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        logic w_pe;
`ifdef UART_RX_PARITY_EN
        w_pe = parity_err;
`else
        w_pe = 1'b0;
`endif
        if (byte_valid) begin
            vcnt++;
            rx_q.push_back(byte_out);
        end
        if (frame_err) fcnt++;
        if (w_pe) pcnt++;
        if ((byte_valid && frame_err) || (byte_valid && w_pe) || (frame_err && w_pe) ||
            (byte_valid && prev_v) || (frame_err && prev_f))
            bad_strobe++;
        prev_v = byte_valid;
        prev_f = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit,
                              input logic par_en, input logic par);
        hold(1'b0, c_BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                hold(d[i], 20);
                hold(~d[i], 20);
                hold(d[i], c_BIT - 40);
            end else begin
                hold(d[i], c_BIT);
            end
        end
        if (par_en) hold(par, c_BIT);
        hold(stop, c_BIT);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; vcnt = 0; fcnt = 0; pcnt = 0; bad_strobe = 0;
        prev_v = 1'b0; prev_f = 1'b0;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_byte_out", 32'(byte_out), 32'h0);
        check("rst_byte_valid", 32'(byte_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        hold(1'b1, 100);

        // back-to-back frames
        send_frame(8'h55, 1'b1, -1, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, -1, 1'b0, 1'b0);
        hold(1'b1, 200);
        check("b2b_count", 32'(vcnt), 32'd2);
        check("b2b_byte0", 32'(rx_q[0]), 32'h55);
        check("b2b_byte1", 32'(rx_q[1]), 32'hA3);
        check("b2b_ferr", 32'(fcnt), 32'd0);

        // false start
        hold(1'b0, 50);
        check("fs_busy_high", 32'(busy), 32'd1);
        hold(1'b0, 50);
        hold(1'b1, 16 * 27 + 100);
        check("fs_busy_low", 32'(busy), 32'd0);
        check("fs_no_valid", 32'(vcnt), 32'd2);
        check("fs_no_ferr", 32'(fcnt), 32'd0);

        // framing error with long break, then recovery
        send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0);
        hold(1'b0, 5000);
        check("fe_count", 32'(fcnt), 32'd1);
        check("fe_byte_held", 32'(byte_out), 32'hA3);
        check("fe_busy_in_break", 32'(busy), 32'd1);
        hold(1'b1, 1000);
        check("fe_busy_released", 32'(busy), 32'd0);
        send_frame(8'h7E, 1'b1, -1, 1'b0, 1'b0);
        hold(1'b1, 200);
        check("fe_next_count", 32'(vcnt), 32'd3);
        check("fe_next_byte", 32'(rx_q[$]), 32'h7E);
        check("fe_single_ferr", 32'(fcnt), 32'd1);

        // glitch away from mid-bit
        send_frame(8'h0F, 1'b1, 3, 1'b0, 1'b0);
        hold(1'b1, 200);
        check("glitch_count", 32'(vcnt), 32'd4);
        check("glitch_byte", 32'(rx_q[$]), 32'h0F);

        // reset mid-frame
        hold(1'b0, c_BIT);
        hold(1'b1, 4 * c_BIT + 100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_byte", 32'(byte_out), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        hold(1'b1, 5 * c_BIT);
        check("mid_rst_no_strobe", 32'(vcnt + fcnt), 32'd5);
        send_frame(8'h81, 1'b1, -1, 1'b0, 1'b0);
        hold(1'b1, 200);
        check("post_rst_count", 32'(vcnt), 32'd5);
        check("post_rst_byte", 32'(rx_q[$]), 32'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, -1, 1'b1, 1'b0);
        hold(1'b1, 200);
        check("par_bad_perr", 32'(pcnt), 32'd1);
        check("par_bad_novalid", 32'(vcnt), 32'd5);
        check("par_bad_byte_held", 32'(byte_out), 32'h81);
        send_frame(8'h07, 1'b1, -1, 1'b1, 1'b1);
        hold(1'b1, 200);
        check("par_good_count", 32'(vcnt), 32'd6);
        check("par_good_byte", 32'(rx_q[$]), 32'h07);
        check("par_good_no_perr", 32'(pcnt), 32'd1);
`endif

        check("strobe_exclusive", 32'(bad_strobe), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
